// File: rtl/decode_queue_stage_pkg.sv
// -----------------------------------------------------------------------------
// decode_queue_stage_pkg
// Shared types for the RV32 decode stage: opcodes, funct7 patterns, the
// control-line enums driven towards execute, the decode bundle, and small
// helpers that map funct3 onto ALU operations.
// -----------------------------------------------------------------------------
package decode_queue_stage_pkg;

  typedef logic [31:0] word;
  typedef logic [4:0]  reg_index;

  localparam logic [6:0] OPCODE_R      = 7'b0110011;
  localparam logic [6:0] OPCODE_I      = 7'b0010011;
  localparam logic [6:0] OPCODE_LW     = 7'b0000011;
  localparam logic [6:0] OPCODE_SW     = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

  localparam logic [6:0] FUNCT7_ZERO = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
  localparam logic [6:0] FUNCT7_M    = 7'b0000001;

  typedef enum logic [1:0] {
    NO_REG_DATA, REG_DATA_ALU, REG_DATA_MEM, REG_DATA_PC4
  } reg_data_t;

  typedef enum logic [4:0] {
    NO_ALU_OP, OP_ALU_ADD, OP_ALU_SUB, OP_ALU_SLL, OP_ALU_SLT, OP_ALU_SLTU,
    OP_ALU_XOR, OP_ALU_SRL, OP_ALU_SRA, OP_ALU_OR, OP_ALU_AND,
    OP_ALU_MUL, OP_ALU_MULH, OP_ALU_MULHSU, OP_ALU_MULHU,
    OP_ALU_DIV, OP_ALU_DIVU, OP_ALU_REM, OP_ALU_REMU
  } alu_op_t;

  typedef enum logic [1:0] {ALU_RS1_OP, ALU_PC_OP, ALU_ZERO_OP} alu_rs1_t;
  typedef enum logic       {ALU_RS2_OP, ALU_IMM_OP}             alu_rs2_t;
  typedef enum logic [1:0] {MEM_SKIP_OP, MEM_LOAD_OP, MEM_STORE_OP} mem_op_t;
  typedef enum logic       {NO_WRITE_BACK, WRITE_BACK}          write_back_t;
  typedef enum logic [2:0] {
    NO_BRANCH, BRANCH_BEQ, BRANCH_BNE, BRANCH_BLT, BRANCH_BGE, BRANCH_BLTU, BRANCH_BGEU
  } branch_t;
  typedef enum logic {BRANCH_DISABLE, BRANCH_ENABLE} branch_en_t;
  typedef enum logic {JAL_DISABLE, JAL_ENABLE}       jal_t;
  typedef enum logic {JALR_DISABLE, JALR_ENABLE}     jalr_t;

  typedef struct packed {
    reg_data_t   reg_file_op;
    alu_op_t     alu_op;
    alu_rs1_t    alu_rs1_val;
    alu_rs2_t    alu_rs2_val;
    mem_op_t     mem_op;
    logic [2:0]  mem_width;   // load/store funct3 (size and sign)
    write_back_t write_back;
    branch_t     branch_op;
    branch_en_t  branch_enable;
    jal_t        jal_enable;
    jalr_t       jalr_enable;
  } control_signals_t;

  localparam control_signals_t CTRL_DEFAULT = '{
    reg_file_op:   NO_REG_DATA,
    alu_op:        NO_ALU_OP,
    alu_rs1_val:   ALU_RS1_OP,
    alu_rs2_val:   ALU_RS2_OP,
    mem_op:        MEM_SKIP_OP,
    mem_width:     3'b000,
    write_back:    NO_WRITE_BACK,
    branch_op:     NO_BRANCH,
    branch_enable: BRANCH_DISABLE,
    jal_enable:    JAL_DISABLE,
    jalr_enable:   JALR_DISABLE
  };

  typedef struct packed {
    control_signals_t ctrl;
    reg_index         rs1;
    reg_index         rs2;
    reg_index         rd;
    word              imm;
    word              pc;
    logic             illegal;
  } decode_bundle_t;

  localparam decode_bundle_t BUNDLE_RESET = '{
    ctrl: CTRL_DEFAULT, rs1: '0, rs2: '0, rd: '0, imm: '0, pc: '0, illegal: 1'b0
  };

  // Base integer ops shared by OP and OP-IMM (funct7 = 0 variants)
  function automatic alu_op_t base_alu_op(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return OP_ALU_ADD;
      3'b001:  return OP_ALU_SLL;
      3'b010:  return OP_ALU_SLT;
      3'b011:  return OP_ALU_SLTU;
      3'b100:  return OP_ALU_XOR;
      3'b101:  return OP_ALU_SRL;
      3'b110:  return OP_ALU_OR;
      default: return OP_ALU_AND;
    endcase
  endfunction

  function automatic alu_op_t m_alu_op(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return OP_ALU_MUL;
      3'b001:  return OP_ALU_MULH;
      3'b010:  return OP_ALU_MULHSU;
      3'b011:  return OP_ALU_MULHU;
      3'b100:  return OP_ALU_DIV;
      3'b101:  return OP_ALU_DIVU;
      3'b110:  return OP_ALU_REM;
      default: return OP_ALU_REMU;
    endcase
  endfunction

endpackage

// File: rtl/immediate_generator.sv
// -----------------------------------------------------------------------------
// immediate_generator
// Combinational immediate extraction selected by opcode.
//   instruction  in   raw 32-bit instruction
//   immediate    out  sign-extended I/S/B/U/J immediate, 0 for R-type/unknown
// -----------------------------------------------------------------------------
module immediate_generator
  import decode_queue_stage_pkg::*;
(
  input  word instruction,
  output word immediate
);

  always_comb begin
    immediate = '0;
    case (instruction[6:0])
      OPCODE_I, OPCODE_LW, OPCODE_JALR:
        immediate = {{20{instruction[31]}}, instruction[31:20]};
      OPCODE_SW:
        immediate = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      OPCODE_BRANCH:
        immediate = {{19{instruction[31]}}, instruction[31], instruction[7],
                     instruction[30:25], instruction[11:8], 1'b0};
      OPCODE_JAL:
        immediate = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                     instruction[20], instruction[30:21], 1'b0};
      OPCODE_LUI, OPCODE_AUIPC:
        immediate = {instruction[31:12], 12'h000};
      default:
        immediate = '0;
    endcase
  end

endmodule

// File: rtl/instruction_decoder.sv
// -----------------------------------------------------------------------------
// instruction_decoder
// Pure combinational RV32I (+ optional RV32M) decode with illegal flagging.
//   ENABLE_M     1 = decode funct7 0000001 on OPCODE_R as M ops, 0 = illegal
//   instruction  in   raw instruction
//   ctrl         out  control lines (defaults when illegal)
//   rs1/rs2/rd   out  raw register fields
//   immediate    out  selected immediate (0 when illegal)
//   illegal      out  not decodable under current parameters
// -----------------------------------------------------------------------------
module instruction_decoder
  import decode_queue_stage_pkg::*;
#(
  parameter bit ENABLE_M = 1'b0
) (
  input  word              instruction,
  output control_signals_t ctrl,
  output reg_index         rs1_index,
  output reg_index         rs2_index,
  output reg_index         rd_index,
  output word              immediate,
  output logic             illegal
);

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  word              imm_raw;
  control_signals_t ctrl_raw;
  logic             bad;

  assign opcode    = instruction[6:0];
  assign funct3    = instruction[14:12];
  assign funct7    = instruction[31:25];
  assign rs1_index = instruction[19:15];
  assign rs2_index = instruction[24:20];
  assign rd_index  = instruction[11:7];

  immediate_generator u_imm_gen (
    .instruction (instruction),
    .immediate   (imm_raw)
  );

  always_comb begin
    ctrl_raw = CTRL_DEFAULT;
    bad      = (instruction[1:0] != 2'b11);
    case (opcode)
      OPCODE_R: begin
        ctrl_raw.reg_file_op = REG_DATA_ALU;
        ctrl_raw.write_back  = WRITE_BACK;
        if (funct7 == FUNCT7_ZERO)
          ctrl_raw.alu_op = base_alu_op(funct3);
        else if (funct7 == FUNCT7_ALT && funct3 == 3'b000)
          ctrl_raw.alu_op = OP_ALU_SUB;
        else if (funct7 == FUNCT7_ALT && funct3 == 3'b101)
          ctrl_raw.alu_op = OP_ALU_SRA;
        else if (ENABLE_M && funct7 == FUNCT7_M)
          ctrl_raw.alu_op = m_alu_op(funct3);
        else
          bad = 1'b1;
      end
      OPCODE_I: begin
        ctrl_raw.reg_file_op = REG_DATA_ALU;
        ctrl_raw.write_back  = WRITE_BACK;
        ctrl_raw.alu_rs2_val = ALU_IMM_OP;
        ctrl_raw.alu_op      = base_alu_op(funct3);
        // Shift-immediates reuse imm[11:5] as a funct7 qualifier
        if (funct3 == 3'b001 && funct7 != FUNCT7_ZERO) bad = 1'b1;
        if (funct3 == 3'b101) begin
          if (funct7 == FUNCT7_ALT)       ctrl_raw.alu_op = OP_ALU_SRA;
          else if (funct7 != FUNCT7_ZERO) bad = 1'b1;
        end
      end
      OPCODE_LW: begin
        ctrl_raw.reg_file_op = REG_DATA_MEM;
        ctrl_raw.write_back  = WRITE_BACK;
        ctrl_raw.alu_op      = OP_ALU_ADD;
        ctrl_raw.alu_rs2_val = ALU_IMM_OP;
        ctrl_raw.mem_op      = MEM_LOAD_OP;
        ctrl_raw.mem_width   = funct3;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) bad = 1'b1;
      end
      OPCODE_SW: begin
        ctrl_raw.alu_op      = OP_ALU_ADD;
        ctrl_raw.alu_rs2_val = ALU_IMM_OP;
        ctrl_raw.mem_op      = MEM_STORE_OP;
        ctrl_raw.mem_width   = funct3;
        if (funct3 > 3'b010) bad = 1'b1;
      end
      OPCODE_BRANCH: begin
        ctrl_raw.alu_op        = OP_ALU_SUB;
        ctrl_raw.branch_enable = BRANCH_ENABLE;
        case (funct3)
          3'b000:  ctrl_raw.branch_op = BRANCH_BEQ;
          3'b001:  ctrl_raw.branch_op = BRANCH_BNE;
          3'b100:  ctrl_raw.branch_op = BRANCH_BLT;
          3'b101:  ctrl_raw.branch_op = BRANCH_BGE;
          3'b110:  ctrl_raw.branch_op = BRANCH_BLTU;
          3'b111:  ctrl_raw.branch_op = BRANCH_BGEU;
          default: bad = 1'b1;
        endcase
      end
      OPCODE_JAL: begin
        ctrl_raw.reg_file_op = REG_DATA_PC4;
        ctrl_raw.write_back  = WRITE_BACK;
        ctrl_raw.alu_op      = OP_ALU_ADD;
        ctrl_raw.alu_rs1_val = ALU_PC_OP;
        ctrl_raw.alu_rs2_val = ALU_IMM_OP;
        ctrl_raw.jal_enable  = JAL_ENABLE;
      end
      OPCODE_JALR: begin
        ctrl_raw.reg_file_op = REG_DATA_PC4;
        ctrl_raw.write_back  = WRITE_BACK;
        ctrl_raw.alu_op      = OP_ALU_ADD;
        ctrl_raw.alu_rs2_val = ALU_IMM_OP;
        ctrl_raw.jalr_enable = JALR_ENABLE;
        if (funct3 != 3'b000) bad = 1'b1;
      end
      OPCODE_LUI: begin
        ctrl_raw.reg_file_op = REG_DATA_ALU;
        ctrl_raw.write_back  = WRITE_BACK;
        ctrl_raw.alu_op      = OP_ALU_ADD;
        ctrl_raw.alu_rs1_val = ALU_ZERO_OP;
        ctrl_raw.alu_rs2_val = ALU_IMM_OP;
      end
      OPCODE_AUIPC: begin
        ctrl_raw.reg_file_op = REG_DATA_ALU;
        ctrl_raw.write_back  = WRITE_BACK;
        ctrl_raw.alu_op      = OP_ALU_ADD;
        ctrl_raw.alu_rs1_val = ALU_PC_OP;
        ctrl_raw.alu_rs2_val = ALU_IMM_OP;
      end
      default: bad = 1'b1;
    endcase
  end

  // An illegal instruction must not cause side effects downstream
  assign ctrl      = bad ? CTRL_DEFAULT : ctrl_raw;
  assign immediate = bad ? '0 : imm_raw;
  assign illegal   = bad;

endmodule

// File: rtl/decode_queue_stage.sv
// -----------------------------------------------------------------------------
// decode_queue_stage
// Buffered decode stage between fetch and execute: FIFO of fetched
// {instruction, pc}, combinational decode of the head, registered bundle.
//   FIFO_DEPTH        queue entries (power of two, >= 2)
//   ENABLE_M          decode RV32M when 1
//   clock, reset      pipeline clock, async active-high reset
//   flush             sync flush: empties queue and output register
//   in_valid/in_ready/in_instruction/in_pc   fetch handshake
//   out_valid/out_ready                      execute handshake
//   ctrl_signals, rs1/rs2/rd_index, immediate, pc, illegal   decode bundle
// -----------------------------------------------------------------------------
module decode_queue_stage
  import decode_queue_stage_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          ENABLE_M   = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  word              in_instruction,
  input  word              in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output control_signals_t ctrl_signals,
  output reg_index         rs1_index,
  output reg_index         rs2_index,
  output reg_index         rd_index,
  output word              immediate,
  output word              pc,
  output logic             illegal
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  word                fifo_instr_q [FIFO_DEPTH];
  word                fifo_instr_d [FIFO_DEPTH];
  word                fifo_pc_q    [FIFO_DEPTH];
  word                fifo_pc_d    [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               out_valid_q, out_valid_d;
  decode_bundle_t     bundle_q, bundle_d;

  logic               full, empty, push_en, pop_en;
  control_signals_t   dec_ctrl;
  reg_index           dec_rs1, dec_rs2, dec_rd;
  word                dec_imm;
  logic               dec_illegal;

  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  // Full refuses a push even if the head pops this cycle
  assign in_ready = !full && !flush;
  assign push_en  = in_valid && in_ready;
  assign pop_en   = !empty && (!out_valid_q || out_ready);

  instruction_decoder #(
    .ENABLE_M (ENABLE_M)
  ) u_decoder (
    .instruction (fifo_instr_q[rd_ptr_q]),
    .ctrl        (dec_ctrl),
    .rs1_index   (dec_rs1),
    .rs2_index   (dec_rs2),
    .rd_index    (dec_rd),
    .immediate   (dec_imm),
    .illegal     (dec_illegal)
  );

  always_comb begin
    fifo_instr_d = fifo_instr_q;
    fifo_pc_d    = fifo_pc_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    out_valid_d  = out_valid_q;
    bundle_d     = bundle_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (push_en) begin
        fifo_instr_d[wr_ptr_q] = in_instruction;
        fifo_pc_d[wr_ptr_q]    = in_pc;
        wr_ptr_d               = wr_ptr_q + PTR_W'(1);
      end
      if (pop_en) begin
        bundle_d = '{ctrl: dec_ctrl, rs1: dec_rs1, rs2: dec_rs2, rd: dec_rd,
                     imm: dec_imm, pc: fifo_pc_q[rd_ptr_q], illegal: dec_illegal};
        rd_ptr_d    = rd_ptr_q + PTR_W'(1);
        out_valid_d = 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      count_d = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      bundle_q    <= BUNDLE_RESET;
    end else begin
      fifo_instr_q <= fifo_instr_d;
      fifo_pc_q    <= fifo_pc_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      bundle_q     <= bundle_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign ctrl_signals = bundle_q.ctrl;
  assign rs1_index    = bundle_q.rs1;
  assign rs2_index    = bundle_q.rs2;
  assign rd_index     = bundle_q.rd;
  assign immediate    = bundle_q.imm;
  assign pc           = bundle_q.pc;
  assign illegal      = bundle_q.illegal;

endmodule
